// File: rtl/hamming_secded_cozucu.sv
// Purpose    : SECDED decoder for a 39-bit Hamming codeword (32 data, 6 check, 1 overall parity),
//              correcting single-bit errors and flagging double-bit errors, with saturating counters.
// Latency    : 2 cycles from accepted codeword to veri_gecerli_o; one word per cycle sustained.
// Backpressure: single global stall (veri_gecerli_o && !veri_hazir_i) freezes both stages and
//              drops kod_hazir_o combinationally; outputs are held stable while stalled.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   kod_gecerli_i / kod_hazir_o        input handshake; kod_kelimesi_i bit p = Hamming position p
//   veri_gecerli_o / veri_hazir_i      output handshake; veri_o, tek_hata_o, cift_hata_o, sendrom_o
//   sayac_temizle_i                    clears both counters (wins over a coincident increment)
//   tek_hata_sayisi_o, cift_hata_sayisi_o  saturating counts of delivered single/double error words
module hamming_secded_cozucu #(
  parameter int SAYAC_BIT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 kod_gecerli_i,
  output logic                 kod_hazir_o,
  input  logic [38:0]          kod_kelimesi_i,
  output logic                 veri_gecerli_o,
  input  logic                 veri_hazir_i,
  output logic [31:0]          veri_o,
  output logic                 tek_hata_o,
  output logic                 cift_hata_o,
  output logic [5:0]           sendrom_o,
  input  logic                 sayac_temizle_i,
  output logic [SAYAC_BIT-1:0] tek_hata_sayisi_o,
  output logic [SAYAC_BIT-1:0] cift_hata_sayisi_o
);

  // Pull the 32 data bits out of the non-power-of-two positions 3..38, in ascending order.
  function automatic logic [31:0] veri_cikar(input logic [38:0] kod);
    logic [31:0] v;
    int          j;
    v = '0;
    j = 0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        v[j] = kod[p];
        j++;
      end
    end
    return v;
  endfunction

  logic        ilerle;
  logic        cikis_el;

  // Stage 1 registers
  logic        s1_vld;
  logic [38:0] s1_kod;
  logic [5:0]  s1_sen;
  logic        s1_par;

  // Stage 1 combinational syndrome / overall parity
  logic [5:0]  sen_c;
  logic        par_c;

  // Stage 2 combinational correction
  logic [38:0] duz_kod;
  logic [31:0] veri_c;
  logic        tek_c;
  logic        cift_c;

  // Whole pipeline moves together: any slot may advance as long as the output slot empties.
  assign ilerle      = !veri_gecerli_o || veri_hazir_i;
  assign kod_hazir_o = ilerle;
  assign cikis_el    = veri_gecerli_o && veri_hazir_i;

  always_comb begin
    sen_c = '0;
    for (int k = 0; k < 6; k++) begin
      for (int p = 1; p < 39; p++) begin
        if (((p >> k) & 1) == 1) begin
          sen_c[k] = sen_c[k] ^ kod_kelimesi_i[p];
        end
      end
    end
    par_c = ^kod_kelimesi_i;
  end

  always_comb begin
    duz_kod = s1_kod;
    tek_c   = 1'b0;
    cift_c  = 1'b0;
    if (s1_par) begin
      if (s1_sen == 6'd0) begin
        // Only the overall parity bit itself flipped; data is intact.
        tek_c = 1'b1;
      end else if (s1_sen <= 6'd38) begin
        tek_c           = 1'b1;
        duz_kod[s1_sen] = ~duz_kod[s1_sen];
      end else begin
        // Odd error count pointing outside the codeword: cannot be a single error.
        cift_c = 1'b1;
      end
    end else if (s1_sen != 6'd0) begin
      cift_c = 1'b1;
    end
    // On a double error duz_kod is untouched, so the raw data bits are delivered.
    veri_c = veri_cikar(duz_kod);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld         <= 1'b0;
      s1_kod         <= '0;
      s1_sen         <= '0;
      s1_par         <= 1'b0;
      veri_gecerli_o <= 1'b0;
      veri_o         <= '0;
      tek_hata_o     <= 1'b0;
      cift_hata_o    <= 1'b0;
      sendrom_o      <= '0;
    end else if (ilerle) begin
      s1_vld <= kod_gecerli_i;
      if (kod_gecerli_i) begin
        s1_kod <= kod_kelimesi_i;
        s1_sen <= sen_c;
        s1_par <= par_c;
      end
      veri_gecerli_o <= s1_vld;
      if (s1_vld) begin
        veri_o      <= veri_c;
        tek_hata_o  <= tek_c;
        cift_hata_o <= cift_c;
        sendrom_o   <= s1_sen;
      end
    end
  end

  // Counters only see words actually taken by the consumer.
  always_ff @(posedge clk_i) begin
    if (rst_i || sayac_temizle_i) begin
      tek_hata_sayisi_o  <= '0;
      cift_hata_sayisi_o <= '0;
    end else if (cikis_el) begin
      if (tek_hata_o && (tek_hata_sayisi_o != '1)) begin
        tek_hata_sayisi_o <= tek_hata_sayisi_o + 1'b1;
      end
      if (cift_hata_o && (cift_hata_sayisi_o != '1)) begin
        cift_hata_sayisi_o <= cift_hata_sayisi_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_cozucu.sv
// Purpose    : self-checking bench for hamming_secded_cozucu against a position-arithmetic model.
// Latency    : checks the 2-cycle latency on an idle pipeline.
// Backpressure: random and directed veri_hazir_i stalls; checks hold-stability and kod_hazir_o.
module tb_hamming_secded_cozucu;

  localparam int SB  = 4;
  localparam int MAX = (1 << SB) - 1;

  typedef struct packed {
    logic [31:0] d;
    logic        tek;
    logic        cift;
    logic [5:0]  syn;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i, kod_gecerli_i, veri_hazir_i, sayac_temizle_i;
  logic [38:0]   kod_kelimesi_i;
  logic          kod_hazir_o, veri_gecerli_o, tek_hata_o, cift_hata_o;
  logic [31:0]   veri_o;
  logic [5:0]    sendrom_o;
  logic [SB-1:0] tek_hata_sayisi_o, cift_hata_sayisi_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  hamming_secded_cozucu #(.SAYAC_BIT(SB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .kod_gecerli_i(kod_gecerli_i), .kod_hazir_o(kod_hazir_o), .kod_kelimesi_i(kod_kelimesi_i),
    .veri_gecerli_o(veri_gecerli_o), .veri_hazir_i(veri_hazir_i), .veri_o(veri_o),
    .tek_hata_o(tek_hata_o), .cift_hata_o(cift_hata_o), .sendrom_o(sendrom_o),
    .sayac_temizle_i(sayac_temizle_i),
    .tek_hata_sayisi_o(tek_hata_sayisi_o), .cift_hata_sayisi_o(cift_hata_sayisi_o)
  );

  // Encoder: data at non-power-of-two positions, check bit 2^k makes the XOR of all
  // positions having bit k set equal to zero, bit 0 makes the total parity even.
  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [38:0] c;
    logic        x;
    int          j;
    c = '0;
    j = 0;
    for (int p = 3; p <= 38; p++) if ((p & (p - 1)) != 0) begin c[p] = d[j]; j++; end
    for (int k = 0; k < 6; k++) begin
      x = 1'b0;
      for (int p = 3; p <= 38; p++) if (((p >> k) & 1) == 1) x = x ^ c[p];
      c[1 << k] = x;
    end
    c[0] = ^c[38:1];
    return c;
  endfunction

  // Reference decode: syndrome as the XOR of the positions of all set bits.
  function automatic exp_t ref_decode(input logic [38:0] cw);
    exp_t        e;
    logic [38:0] fx;
    logic        par;
    int          syn, j;
    syn = 0;
    for (int p = 1; p <= 38; p++) if (cw[p]) syn = syn ^ p;
    par    = ^cw;
    fx     = cw;
    e.tek  = 1'b0;
    e.cift = 1'b0;
    if (par && syn == 0) e.tek = 1'b1;
    else if (par && syn <= 38) begin e.tek = 1'b1; fx[syn] = ~fx[syn]; end
    else if (syn != 0) e.cift = 1'b1;
    e.d = '0;
    j   = 0;
    for (int p = 3; p <= 38; p++) if ((p & (p - 1)) != 0) begin e.d[j] = fx[p]; j++; end
    e.syn = syn[5:0];
    return e;
  endfunction

  // Flip n distinct random positions of a codeword.
  function automatic logic [38:0] corrupt(input logic [38:0] cw, input int n);
    logic [38:0] m;
    int          p;
    m = '0;
    while ($countones(m) < n) begin p = $urandom_range(0, 38); m[p] = 1'b1; end
    return cw ^ m;
  endfunction

  // Sends one word into an idle pipeline and captures the first output; no checking here.
  task automatic run_word(input logic [38:0] cw, input logic clr_hs, output logic got,
                          output int lat, output exp_t obs);
    got = 1'b0; lat = 0; obs = '0;
    kod_kelimesi_i = cw; kod_gecerli_i = 1'b1; veri_hazir_i = 1'b1;
    @(posedge clk_i); #1;
    kod_gecerli_i = 1'b0;
    lat = 1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk_i);
      if (veri_gecerli_o) begin
        got = 1'b1;
        obs = {veri_o, tek_hata_o, cift_hata_o, sendrom_o};
        if (clr_hs) sayac_temizle_i = 1'b1;
      end else begin
        @(posedge clk_i); #1;
        lat++;
      end
    end
    @(posedge clk_i); #1;
    sayac_temizle_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; kod_gecerli_i = 1'b0; veri_hazir_i = 1'b0; sayac_temizle_i = 1'b0;
    kod_kelimesi_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (veri_gecerli_o !== 1'b0) $display("FAIL rst_vld got=%b exp=0", veri_gecerli_o);
    else if (0) errors++;
    if (veri_gecerli_o !== 1'b0) errors++;
    checks++; if (kod_hazir_o !== 1'b1) begin errors++; $display("FAIL rst_hazir got=%b exp=1", kod_hazir_o); end
    checks++;
    if ({veri_o, tek_hata_o, cift_hata_o, sendrom_o} !== 40'd0) begin
      errors++; $display("FAIL rst_outs got=%h exp=0", {veri_o, tek_hata_o, cift_hata_o, sendrom_o});
    end
    checks++;
    if (tek_hata_sayisi_o !== '0 || cift_hata_sayisi_o !== '0) begin
      errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", tek_hata_sayisi_o, cift_hata_sayisi_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_zero;
    logic got; int lat; exp_t o;
    run_word(39'd0, 1'b0, got, lat, o);
    checks++; if (!got || lat != 2) begin errors++; $display("FAIL zero_latency got=%0d/%b exp=2", lat, got); end
    checks++; if (o !== exp_t'(0)) begin errors++; $display("FAIL zero_out got=%h exp=0", o); end
  endtask

  task automatic test_single;
    logic got; int lat; exp_t o; exp_t e;
    e = '{d: 32'hDEADBEEF, tek: 1'b1, cift: 1'b0, syn: 6'd3};
    run_word(encode(32'hDEADBEEF) ^ (39'd1 << 3), 1'b0, got, lat, o);
    checks++; if (!got || o !== e) begin errors++; $display("FAIL single_pos3 got=%h exp=%h", o, e); end
    checks++; if (tek_hata_sayisi_o !== 4'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", tek_hata_sayisi_o); end
  endtask

  task automatic test_double;
    logic got; int lat; exp_t o; exp_t e; logic [38:0] cw;
    cw = encode(32'hDEADBEEF) ^ (39'd1 << 5) ^ (39'd1 << 9);
    e  = ref_decode(cw);
    run_word(cw, 1'b0, got, lat, o);
    checks++;
    if (!got || o.tek !== 1'b0 || o.cift !== 1'b1 || o.syn !== 6'd12) begin
      errors++; $display("FAIL double_flags got=%b%b/%0d exp=01/12", o.tek, o.cift, o.syn);
    end
    checks++; if (o.d !== e.d) begin errors++; $display("FAIL double_data got=%h exp=%h", o.d, e.d); end
    checks++; if (cift_hata_sayisi_o !== 4'd1) begin errors++; $display("FAIL double_cnt got=%0d exp=1", cift_hata_sayisi_o); end
  endtask

  task automatic test_bit0;
    logic got; int lat; exp_t o; exp_t e;
    e = '{d: 32'hDEADBEEF, tek: 1'b1, cift: 1'b0, syn: 6'd0};
    run_word(encode(32'hDEADBEEF) ^ 39'd1, 1'b0, got, lat, o);
    checks++; if (!got || o !== e) begin errors++; $display("FAIL bit0 got=%h exp=%h", o, e); end
    checks++; if (tek_hata_sayisi_o !== 4'd2) begin errors++; $display("FAIL bit0_cnt got=%0d exp=2", tek_hata_sayisi_o); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w[4];
    logic [38:0] cw[4];
    logic [32:0] pr;
    logic        hold;
    int          sent, rcvd, extra;
    sent = 0; rcvd = 0; hold = 1'b0; pr = '0; extra = 0;
    for (int i = 0; i < 4; i++) begin w[i] = $urandom; cw[i] = corrupt(encode(w[i]), i % 2); end
    for (int cyc = 0; cyc < 30 && rcvd < 4; cyc++) begin
      kod_gecerli_i  = (sent < 4);
      kod_kelimesi_i = cw[(sent < 4) ? sent : 0];
      veri_hazir_i   = !(cyc >= 3 && cyc <= 5);
      @(negedge clk_i);
      if (hold) begin
        checks++;
        if (!veri_gecerli_o || {veri_o, tek_hata_o} !== pr) begin
          errors++; $display("FAIL b2b_hold got=%h exp=%h", {veri_o, tek_hata_o}, pr);
        end
      end
      if (veri_gecerli_o && !veri_hazir_i) begin
        checks++; if (kod_hazir_o !== 1'b0) begin errors++; $display("FAIL b2b_hazir got=%b exp=0", kod_hazir_o); end
      end
      if (kod_gecerli_i && kod_hazir_o) sent++;
      if (veri_gecerli_o && veri_hazir_i) begin
        checks++;
        if (veri_o !== w[rcvd] || tek_hata_o !== ((rcvd % 2) == 1)) begin
          errors++; $display("FAIL b2b_word%0d got=%h exp=%h", rcvd, veri_o, w[rcvd]);
        end
        rcvd++;
      end
      hold = veri_gecerli_o && !veri_hazir_i;
      pr   = {veri_o, tek_hata_o};
      @(posedge clk_i); #1;
    end
    kod_gecerli_i = 1'b0; veri_hazir_i = 1'b1;
    checks++; if (rcvd != 4 || sent != 4) begin errors++; $display("FAIL b2b_count got=%0d/%0d exp=4/4", sent, rcvd); end
    repeat (4) begin @(negedge clk_i); if (veri_gecerli_o) extra++; @(posedge clk_i); #1; end
    checks++; if (extra != 0) begin errors++; $display("FAIL b2b_dup got=%0d exp=0", extra); end
  endtask

  task automatic test_random;
    exp_t        q[$];
    exp_t        e, pr;
    logic        hold, have;
    logic [38:0] cw;
    int          mt, mc;
    hold = 1'b0; have = 1'b0; mt = 0; mc = 0; pr = '0; cw = '0;
    sayac_temizle_i = 1'b1; kod_gecerli_i = 1'b0; veri_hazir_i = 1'b1;
    @(posedge clk_i); #1;
    sayac_temizle_i = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!have) begin cw = corrupt(encode($urandom), $urandom_range(0, 3)); have = 1'b1; end
      kod_kelimesi_i = cw;
      kod_gecerli_i  = (cyc < 360) && ($urandom_range(0, 3) != 0);
      veri_hazir_i   = ($urandom_range(0, 9) < 7);
      @(negedge clk_i);
      checks++;
      if (kod_hazir_o !== (!veri_gecerli_o || veri_hazir_i)) begin
        errors++; $display("FAIL rnd_hazir got=%b vld=%b rdy=%b", kod_hazir_o, veri_gecerli_o, veri_hazir_i);
      end
      if (hold) begin
        checks++;
        if (!veri_gecerli_o || {veri_o, tek_hata_o, cift_hata_o, sendrom_o} !== pr) begin
          errors++; $display("FAIL rnd_hold got=%h exp=%h", {veri_o, tek_hata_o, cift_hata_o, sendrom_o}, pr);
        end
      end
      if (kod_gecerli_i && kod_hazir_o) begin q.push_back(ref_decode(cw)); have = 1'b0; end
      if (veri_gecerli_o && veri_hazir_i) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra got=%h exp=none", veri_o);
        end else begin
          e = q.pop_front();
          if ({veri_o, tek_hata_o, cift_hata_o, sendrom_o} !== e) begin
            errors++; $display("FAIL rnd_word got=%h exp=%h", {veri_o, tek_hata_o, cift_hata_o, sendrom_o}, e);
          end
          if (e.tek && mt < MAX) mt++;
          if (e.cift && mc < MAX) mc++;
        end
      end
      hold = veri_gecerli_o && !veri_hazir_i;
      pr   = {veri_o, tek_hata_o, cift_hata_o, sendrom_o};
      @(posedge clk_i); #1;
    end
    kod_gecerli_i = 1'b0; veri_hazir_i = 1'b1;
    @(negedge clk_i);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_lost got=%0d exp=0", q.size()); end
    checks++;
    if (tek_hata_sayisi_o !== SB'(mt) || cift_hata_sayisi_o !== SB'(mc)) begin
      errors++; $display("FAIL rnd_cnt got=%0d/%0d exp=%0d/%0d", tek_hata_sayisi_o, cift_hata_sayisi_o, mt, mc);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_saturation;
    logic got; int lat; exp_t o;
    sayac_temizle_i = 1'b1; @(posedge clk_i); #1; sayac_temizle_i = 1'b0;
    for (int i = 0; i < MAX + 3; i++) begin
      run_word(corrupt(encode($urandom), 1), 1'b0, got, lat, o);
    end
    checks++; if (tek_hata_sayisi_o !== SB'(MAX)) begin errors++; $display("FAIL sat_hold got=%0d exp=%0d", tek_hata_sayisi_o, MAX); end
    checks++; if (cift_hata_sayisi_o !== '0) begin errors++; $display("FAIL sat_cift got=%0d exp=0", cift_hata_sayisi_o); end
    run_word(encode(32'hA5A5_0F0F) ^ (39'd1 << 17), 1'b1, got, lat, o);
    checks++; if (!got || o.tek !== 1'b1) begin errors++; $display("FAIL clr_word got=%b exp=1", o.tek); end
    checks++; if (tek_hata_sayisi_o !== '0) begin errors++; $display("FAIL clr_wins got=%0d exp=0", tek_hata_sayisi_o); end
  endtask

  task automatic test_reset_inflight;
    logic got; int lat; exp_t o; int seen;
    seen = 0;
    run_word(encode(32'h1234_5678) ^ (39'd1 << 7), 1'b0, got, lat, o);
    checks++; if (tek_hata_sayisi_o !== 4'd1) begin errors++; $display("FAIL pre_rst_cnt got=%0d exp=1", tek_hata_sayisi_o); end
    kod_gecerli_i = 1'b1; veri_hazir_i = 1'b1;
    kod_kelimesi_i = corrupt(encode($urandom), 1); @(posedge clk_i); #1;
    kod_kelimesi_i = corrupt(encode($urandom), 2); @(posedge clk_i); #1;
    kod_gecerli_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (veri_gecerli_o !== 1'b0) begin errors++; $display("FAIL inflight_vld got=%b exp=0", veri_gecerli_o); end
    checks++;
    if (tek_hata_sayisi_o !== '0 || cift_hata_sayisi_o !== '0) begin
      errors++; $display("FAIL inflight_cnt got=%0d/%0d exp=0/0", tek_hata_sayisi_o, cift_hata_sayisi_o);
    end
    checks++; if (kod_hazir_o !== 1'b1) begin errors++; $display("FAIL inflight_hazir got=%b exp=1", kod_hazir_o); end
    repeat (4) begin @(posedge clk_i); @(negedge clk_i); if (veri_gecerli_o) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL inflight_stale got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_single;
    test_double;
    test_bit0;
    test_back_to_back;
    test_random;
    test_saturation;
    test_reset_inflight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
